// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// decode_ctrl_stage : registered RV32I main decoder (ID/EX control register)
//   with valid/ready handshake, bubbles, divide stall and sticky trap state.
//   Optional macro RV32M_EN enables M-extension decode and the divide stall.
// Revision: 1.0
// ============================================================================
module decode_ctrl_stage #(
    parameter int SRC_W      = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             EN_PC,
    input  logic             NOP_Ins,
    input  logic             if_id_flush,
    input  logic             id_ex_flush,
    input  logic             ex_ready,
    input  logic             trap_clr,
    output logic             out_valid,
    output logic             MEM_Wr_En,
    output logic             MEM_Rd_En,
    output logic             Reg_Wr_En,
    output logic             Branch,
    output logic             Jump,
    output logic             Mul_Div_En,
    output logic             ALU_Src1_Sel,
    output logic             ALU_Src2_Sel,
    output logic [SRC_W-1:0] Src_to_Reg,
    output logic             undef_instr,
    output logic             illegal_trap,
    output logic [CNT_W-1:0] undef_count
);

    localparam int DCW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MDIV_WAIT = 2'd1,
        ST_TRAP      = 2'd2
    } state_t;

    typedef struct packed {
        logic       mem_wr;
        logic       mem_rd;
        logic       reg_wr;
        logic       branch;
        logic       jump;
        logic       mul_div;
        logic       src1;
        logic       src2;
        logic [1:0] wb_src;
        logic       undef;
    } ctl_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   cnt_q, cnt_d;
    logic             valid_q, valid_d;
    ctl_t             ctl_q, ctl_d;
    logic [CNT_W-1:0] undef_cnt_q, undef_cnt_d;

    ctl_t dec;
    logic is_div;
    logic accept;
    logic take;
    logic unused_funct3;

    assign unused_funct3 = ^Funct3;

    always_comb begin
        dec = '0;
        case (Opcode)
            c_op_rtype: begin
`ifdef RV32M_EN
                dec.reg_wr = 1'b1;
                if (Funct7 == c_f7_muldiv) begin
                    dec.mul_div = 1'b1;
                    dec.wb_src  = 2'd3;
                end
`else
                if (Funct7 == c_f7_muldiv) dec.undef  = 1'b1;
                else                       dec.reg_wr = 1'b1;
`endif
            end
            c_op_imm:    begin dec.src2 = 1'b1; dec.reg_wr = 1'b1; end
            c_op_load:   begin dec.src2 = 1'b1; dec.reg_wr = 1'b1; dec.mem_rd = 1'b1; dec.wb_src = 2'd1; end
            c_op_store:  begin dec.src2 = 1'b1; dec.mem_wr = 1'b1; end
            c_op_branch: begin dec.src1 = 1'b1; dec.src2 = 1'b1; dec.branch = 1'b1; end
            c_op_jal:    begin dec.src1 = 1'b1; dec.src2 = 1'b1; dec.reg_wr = 1'b1; dec.jump = 1'b1; dec.wb_src = 2'd2; end
            c_op_jalr:   begin dec.src2 = 1'b1; dec.reg_wr = 1'b1; dec.jump = 1'b1; dec.wb_src = 2'd2; end
            c_op_lui:    begin dec.src2 = 1'b1; dec.reg_wr = 1'b1; end
            c_op_auipc:  begin dec.src1 = 1'b1; dec.src2 = 1'b1; dec.reg_wr = 1'b1; end
            default:     dec.undef = 1'b1;
        endcase
    end

`ifdef RV32M_EN
    assign is_div = dec.mul_div && Funct3[2];
`else
    assign is_div = 1'b0;
`endif

    assign in_ready = (state_q == ST_RUN) && EN_PC && !id_ex_flush && (!valid_q || ex_ready);
    assign accept   = in_valid && in_ready;
    assign take     = accept && !NOP_Ins && !if_id_flush;

    // Flush wins over everything; an idle or consumed word collapses to a clean bubble.
    always_comb begin
        valid_d     = valid_q;
        ctl_d       = ctl_q;
        undef_cnt_d = undef_cnt_q;
        if (id_ex_flush) begin
            valid_d = 1'b0;
            ctl_d   = '0;
        end else if (accept) begin
            valid_d = take;
            ctl_d   = take ? dec : '0;
        end else if (!valid_q || ex_ready) begin
            valid_d = 1'b0;
            ctl_d   = '0;
        end
        if (take && dec.undef && (undef_cnt_q != {CNT_W{1'b1}})) begin
            undef_cnt_d = undef_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (take && dec.undef) begin
                    state_d = ST_TRAP;
                end else if (take && is_div) begin
                    state_d = ST_MDIV_WAIT;
                    cnt_d   = DCW'(DIV_CYCLES - 1);
                end
            end
            ST_MDIV_WAIT: begin
                if (id_ex_flush || (cnt_q == '0)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DCW'(1);
                end
            end
            ST_TRAP: begin
                if (trap_clr) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            ctl_q       <= '0;
            undef_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            ctl_q       <= ctl_d;
            undef_cnt_q <= undef_cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign MEM_Wr_En    = ctl_q.mem_wr;
    assign MEM_Rd_En    = ctl_q.mem_rd;
    assign Reg_Wr_En    = ctl_q.reg_wr;
    assign Branch       = ctl_q.branch;
    assign Jump         = ctl_q.jump;
    assign Mul_Div_En   = ctl_q.mul_div;
    assign ALU_Src1_Sel = ctl_q.src1;
    assign ALU_Src2_Sel = ctl_q.src2;
    assign Src_to_Reg   = SRC_W'(ctl_q.wb_src);
    assign undef_instr  = ctl_q.undef;
    assign illegal_trap = (state_q == ST_TRAP);
    assign undef_count  = undef_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// tb_decode_ctrl_stage : decode table vectors, handshake corner sequences and
//   randomized traffic against a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_decode_ctrl_stage;

    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] Opcode = 7'b0;
    logic [2:0] Funct3 = 3'b0;
    logic [6:0] Funct7 = 7'b0;
    logic       in_valid = 1'b0, EN_PC = 1'b1, NOP_Ins = 1'b0, if_id_flush = 1'b0;
    logic       id_ex_flush = 1'b0, ex_ready = 1'b1, trap_clr = 1'b0;
    logic       in_ready, out_valid, MEM_Wr_En, MEM_Rd_En, Reg_Wr_En, Branch, Jump, Mul_Div_En;
    logic       ALU_Src1_Sel, ALU_Src2_Sel, undef_instr, illegal_trap;
    logic [1:0] Src_to_Reg;
    logic [1:0] undef_count;

    always #5 CLK = ~CLK;

    decode_ctrl_stage #(.SRC_W(2), .DIV_CYCLES(D), .CNT_W(2)) dut (
        .CLK(CLK), .rst_n(rst_n), .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
        .in_valid(in_valid), .in_ready(in_ready), .EN_PC(EN_PC), .NOP_Ins(NOP_Ins),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_ready(ex_ready),
        .trap_clr(trap_clr), .out_valid(out_valid), .MEM_Wr_En(MEM_Wr_En),
        .MEM_Rd_En(MEM_Rd_En), .Reg_Wr_En(Reg_Wr_En), .Branch(Branch), .Jump(Jump),
        .Mul_Div_En(Mul_Div_En), .ALU_Src1_Sel(ALU_Src1_Sel), .ALU_Src2_Sel(ALU_Src2_Sel),
        .Src_to_Reg(Src_to_Reg), .undef_instr(undef_instr), .illegal_trap(illegal_trap),
        .undef_count(undef_count)
    );

    typedef struct packed {
        logic mw, mr, rw, br, jp, md, s1, s2;
        logic [1:0] src;
        logic undef;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        ctl_t       exp;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    logic m_valid, m_trap, last_ready;
    ctl_t m_word;
    int   m_wait, m_cnt;

    function automatic ctl_t mk(input bit mw, mr, rw, br, jp, md, s1, s2,
                                input bit [1:0] src, input bit undef);
        ctl_t c;
        c.mw = mw; c.mr = mr; c.rw = rw; c.br = br; c.jp = jp; c.md = md;
        c.s1 = s1; c.s2 = s2; c.src = src; c.undef = undef;
        return c;
    endfunction

    function automatic ctl_t ref_decode(input logic [6:0] op, input logic [6:0] f7);
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
`ifdef RV32M_EN
                    return mk(0,0,1,0,0,1,0,0,2'd3,0);
`else
                    return mk(0,0,0,0,0,0,0,0,2'd0,1);
`endif
                end
                return mk(0,0,1,0,0,0,0,0,2'd0,0);
            end
            7'b0010011: return mk(0,0,1,0,0,0,0,1,2'd0,0);
            7'b0000011: return mk(0,1,1,0,0,0,0,1,2'd1,0);
            7'b0100011: return mk(1,0,0,0,0,0,0,1,2'd0,0);
            7'b1100011: return mk(0,0,0,1,0,0,1,1,2'd0,0);
            7'b1101111: return mk(0,0,1,0,1,0,1,1,2'd2,0);
            7'b1100111: return mk(0,0,1,0,1,0,0,1,2'd2,0);
            7'b0110111: return mk(0,0,1,0,0,0,0,1,2'd0,0);
            7'b0010111: return mk(0,0,1,0,0,0,1,1,2'd0,0);
            default:    return mk(0,0,0,0,0,0,0,0,2'd0,1);
        endcase
    endfunction

    function automatic ctl_t dut_word();
        return {MEM_Wr_En, MEM_Rd_En, Reg_Wr_En, Branch, Jump, Mul_Div_En,
                ALU_Src1_Sel, ALU_Src2_Sel, Src_to_Reg, undef_instr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        Opcode = op; Funct3 = f3; Funct7 = f7;
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check registered outputs.
    task automatic step();
        logic exp_ready, acc;
        ctl_t dec;
        @(negedge CLK);
        exp_ready = !m_trap && (m_wait == 0) && EN_PC && !id_ex_flush && (!m_valid || ex_ready);
        last_ready = in_ready;
        chk("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;
        dec = ref_decode(Opcode, Funct7);
        if (m_trap && trap_clr) m_trap = 1'b0;
        if (m_wait > 0) m_wait = id_ex_flush ? 0 : m_wait - 1;
        if (id_ex_flush) begin
            m_valid = 1'b0; m_word = '0;
        end else if (acc) begin
            if (NOP_Ins || if_id_flush) begin
                m_valid = 1'b0; m_word = '0;
            end else begin
                m_valid = 1'b1; m_word = dec;
                if (dec.undef) begin
                    m_trap = 1'b1;
                    if (m_cnt < 3) m_cnt++;
                end
                if (dec.md && Funct3[2]) m_wait = D;
            end
        end else if (!m_valid || ex_ready) begin
            m_valid = 1'b0; m_word = '0;
        end
        @(posedge CLK);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("ctl_word", dut_word(), m_word);
        chk("illegal_trap", illegal_trap, m_trap);
        chk("undef_count", undef_count, m_cnt);
    endtask

    task automatic do_reset();
        in_valid = 0; EN_PC = 1; NOP_Ins = 0; if_id_flush = 0; id_ex_flush = 0;
        ex_ready = 1; trap_clr = 0;
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 0; m_word = '0; m_trap = 0; m_wait = 0; m_cnt = 0;
        chk("rst out_valid", out_valid, 0);
        chk("rst ctl_word", dut_word(), 0);
        chk("rst illegal_trap", illegal_trap, 0);
        chk("rst undef_count", undef_count, 0);
        chk("rst in_ready", in_ready, 1);
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[14];
        logic [6:0] ops[9];
        int         zeros;

        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        tbl[0]  = '{7'b0110011, 3'b000, 7'b0000000, mk(0,0,1,0,0,0,0,0,2'd0,0)};
        tbl[1]  = '{7'b0110011, 3'b000, 7'b0100000, mk(0,0,1,0,0,0,0,0,2'd0,0)};
        tbl[2]  = '{7'b0010011, 3'b001, 7'b0000000, mk(0,0,1,0,0,0,0,1,2'd0,0)};
        tbl[3]  = '{7'b0000011, 3'b010, 7'b0000000, mk(0,1,1,0,0,0,0,1,2'd1,0)};
        tbl[4]  = '{7'b0100011, 3'b010, 7'b0000000, mk(1,0,0,0,0,0,0,1,2'd0,0)};
        tbl[5]  = '{7'b1100011, 3'b000, 7'b0000000, mk(0,0,0,1,0,0,1,1,2'd0,0)};
        tbl[6]  = '{7'b1101111, 3'b000, 7'b0000000, mk(0,0,1,0,1,0,1,1,2'd2,0)};
        tbl[7]  = '{7'b1100111, 3'b000, 7'b0000000, mk(0,0,1,0,1,0,0,1,2'd2,0)};
        tbl[8]  = '{7'b0110111, 3'b000, 7'b0000000, mk(0,0,1,0,0,0,0,1,2'd0,0)};
        tbl[9]  = '{7'b0010111, 3'b000, 7'b0000000, mk(0,0,1,0,0,0,1,1,2'd0,0)};
        tbl[10] = '{7'b1111111, 3'b000, 7'b0000000, mk(0,0,0,0,0,0,0,0,2'd0,1)};
        tbl[11] = '{7'b0001111, 3'b000, 7'b0000000, mk(0,0,0,0,0,0,0,0,2'd0,1)};
`ifdef RV32M_EN
        tbl[12] = '{7'b0110011, 3'b000, 7'b0000001, mk(0,0,1,0,0,1,0,0,2'd3,0)};
        tbl[13] = '{7'b0110011, 3'b100, 7'b0000001, mk(0,0,1,0,0,1,0,0,2'd3,0)};
`else
        tbl[12] = '{7'b0110011, 3'b000, 7'b0000001, mk(0,0,0,0,0,0,0,0,2'd0,1)};
        tbl[13] = '{7'b0110011, 3'b100, 7'b0000001, mk(0,0,0,0,0,0,0,0,2'd0,1)};
`endif

        do_reset();

        // Decode table, each vector drained back to an idle RUN stage.
        for (int i = 0; i < 14; i++) begin
            set_ins(tbl[i].op, tbl[i].f3, tbl[i].f7);
            in_valid = 1; ex_ready = 1;
            step();
            chk("vec out_valid", out_valid, 1);
            chk("vec ctl_word", dut_word(), tbl[i].exp);
            in_valid = 0; trap_clr = 1;
            for (int k = 0; k < 20 && (m_trap || m_wait > 0 || m_valid); k++) step();
            trap_clr = 0;
        end

        // R-type then LOAD held under backpressure.
        do_reset();
        set_ins(7'b0110011, 3'b000, 7'b0000000); in_valid = 1;
        step();
        chk("rtype out_valid", out_valid, 1);
        chk("rtype reg_wr", Reg_Wr_En, 1);
        chk("rtype sel", {ALU_Src1_Sel, ALU_Src2_Sel}, 2'b00);
        chk("rtype src", Src_to_Reg, 0);
        set_ins(7'b0000011, 3'b010, 7'b0000000);
        step();
        set_ins(7'b0110011, 3'b000, 7'b0000000); ex_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("load hold valid", out_valid, 1);
            chk("load hold rd", MEM_Rd_En, 1);
            chk("load hold src", Src_to_Reg, 1);
            chk("load hold ready", last_ready, 0);
        end
        ex_ready = 1; in_valid = 0;
        step();
        chk("load consumed", out_valid, 0);

        // Undefined instructions with trap_clr; 2-bit counter saturates at 3.
        do_reset();
        for (int u = 1; u <= 4; u++) begin
            set_ins(7'b1111111, 3'b000, 7'b0000000); in_valid = 1;
            step();
            chk("trap undef_instr", undef_instr, 1);
            chk("trap illegal", illegal_trap, 1);
            chk("trap count", undef_count, (u > 3) ? 3 : u);
            set_ins(7'b0110011, 3'b000, 7'b0000000);
            id_ex_flush = 1;
            step();
            id_ex_flush = 0;
            step();
            chk("trap blocks ready", last_ready, 0);
            chk("trap survives flush", illegal_trap, 1);
            in_valid = 0; trap_clr = 1;
            step();
            trap_clr = 0;
            step();
            chk("trap cleared ready", last_ready, 1);
        end

`ifdef RV32M_EN
        // Divide stall length, multiply without stall, flush out of the wait.
        do_reset();
        set_ins(7'b0110011, 3'b100, 7'b0000001); in_valid = 1;
        step();
        chk("div issued", out_valid, 1);
        chk("div md", Mul_Div_En, 1);
        set_ins(7'b0110011, 3'b000, 7'b0000000);
        zeros = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (last_ready) break;
            zeros++;
        end
        chk("div stall cycles", zeros, D);
        set_ins(7'b0110011, 3'b000, 7'b0000001);
        step();
        set_ins(7'b0110011, 3'b000, 7'b0000000);
        step();
        chk("mul no stall", last_ready, 1);
        set_ins(7'b0110011, 3'b101, 7'b0000001);
        step();
        in_valid = 0; id_ex_flush = 1;
        step();
        id_ex_flush = 0;
        step();
        chk("div flush ready", last_ready, 1);
`endif

        // id_ex_flush blocks a simultaneous accept; the instruction is taken later.
        do_reset();
        set_ins(7'b0010011, 3'b000, 7'b0000000); in_valid = 1; id_ex_flush = 1;
        step();
        chk("flush no accept", last_ready, 0);
        chk("flush out_valid", out_valid, 0);
        id_ex_flush = 0;
        step();
        chk("after flush accept", out_valid, 1);

        // Asynchronous reset while trapped.
        set_ins(7'b1111111, 3'b000, 7'b0000000);
        step();
        chk("pre-reset trap", illegal_trap, 1);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) Opcode = 7'($urandom);
            else                        Opcode = ops[$urandom_range(8)];
            Funct3      = 3'($urandom);
            Funct7      = ($urandom_range(2) == 0) ? 7'b0000001 : 7'($urandom);
            in_valid    = ($urandom_range(9) < 8);
            EN_PC       = ($urandom_range(9) != 0);
            NOP_Ins     = ($urandom_range(9) == 0);
            if_id_flush = ($urandom_range(19) == 0);
            id_ex_flush = ($urandom_range(19) == 0);
            ex_ready    = ($urandom_range(9) < 7);
            trap_clr    = ($urandom_range(3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
